// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side bus of the MEM-stage data-memory controller.
//   master : pipeline (drives requests, receives load data and ready)
//   slave  : mem_sram_ctrl
//   mem_r_en / mem_w_en : load / store request, held while ready=0
//   address             : byte address (ALU result)
//   wr_data             : store data
//   rd_data             : registered load result
//   ready               : high when no access is in progress
interface mem_sram_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              ready;

    modport master (
        output mem_r_en, mem_w_en, address, wr_data,
        input  rd_data, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, wr_data,
        output rd_data, ready
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit SRAM accesses (low half, then high half) and stalls the pipeline
// through ready while the access is in flight.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : pipeline request / load data / ready
//   sram_addr       : SRAM halfword address
//   sram_dq_out     : SRAM write data
//   sram_dq_oe      : high while the controller drives the SRAM data bus
//   sram_dq_in      : SRAM read data
//   sram_we_n       : active-low SRAM write strobe
module mem_sram_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned SRAM_DATA_W = 16,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_sram_ctrl_if.slave         bus,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);
    localparam int unsigned IDX_W = SRAM_ADDR_W - 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rd_data_q;

    logic                   last_c;
    logic [IDX_W-1:0]       idx_in_c;
    logic [IDX_W-1:0]       idx_src;
    logic [DATA_W-1:0]      wdata_src;
    logic [SRAM_ADDR_W-1:0] addr_d;
    logic [SRAM_DATA_W-1:0] dq_out_d;
    logic                   oe_d;
    logic                   we_n_d;

    // Word index of the request: (address - BASE_ADDR) / 4, wrapping silently.
    assign idx_in_c = IDX_W'((bus.address - ADDR_W'(BASE_ADDR)) >> 2);
    assign last_c   = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    assign bus.rd_data = rd_data_q;
    assign bus.ready   = ((state_q == IDLE) && !bus.mem_r_en && !bus.mem_w_en)
                       || (state_q == DONE);

    // State register, counters, captures and registered SRAM outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            sram_addr   <= addr_d;
            sram_dq_out <= dq_out_d;
            sram_dq_oe  <= oe_d;
            sram_we_n   <= we_n_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != IDLE && state_q != DONE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == IDLE && state_d != IDLE) begin
                idx_q   <= idx_in_c;
                wdata_q <= bus.wr_data;
            end

            if (state_q == RD_LO && last_c) begin
                rd_data_q[SRAM_DATA_W-1:0] <= sram_dq_in;
            end
            if (state_q == RD_HI && last_c) begin
                rd_data_q[DATA_W-1:SRAM_DATA_W] <= sram_dq_in;
            end
        end
    end

    // Next-state logic; write wins when both enables are set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_w_en) begin
                    state_d = WR_LO;
                end else if (bus.mem_r_en) begin
                    state_d = RD_LO;
                end
            end
            RD_LO:   if (last_c) state_d = RD_HI;
            RD_HI:   if (last_c) state_d = DONE;
            WR_LO:   if (last_c) state_d = WR_HI;
            WR_HI:   if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM outputs are decoded from the next state so the registered pins
    // line up with the state they belong to; on entry from IDLE the
    // not-yet-captured request fields are used directly.
    always_comb begin
        addr_d    = sram_addr;
        dq_out_d  = sram_dq_out;
        oe_d      = 1'b0;
        we_n_d    = 1'b1;
        idx_src   = (state_q == IDLE) ? idx_in_c : idx_q;
        wdata_src = (state_q == IDLE) ? bus.wr_data : wdata_q;
        case (state_d)
            RD_LO: addr_d = {idx_src, 1'b0};
            RD_HI: addr_d = {idx_src, 1'b1};
            WR_LO: begin
                addr_d   = {idx_src, 1'b0};
                dq_out_d = wdata_src[SRAM_DATA_W-1:0];
                oe_d     = 1'b1;
                we_n_d   = 1'b0;
            end
            WR_HI: begin
                addr_d   = {idx_src, 1'b1};
                dq_out_d = wdata_src[DATA_W-1:SRAM_DATA_W];
                oe_d     = 1'b1;
                we_n_d   = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed scenarios plus randomized
// loads/stores checked cycle by cycle against a word-level reference memory.
module tb_mem_sram_ctrl;
    localparam int unsigned W    = 2;
    localparam int unsigned BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    mem_sram_ctrl_if bus();

    mem_sram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // External SRAM: asynchronous read, write on the clock edge while we_n=0.
    bit [15:0] sram [0:262143];
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;

    // Reference: 32-bit words keyed by word index, plus the expected rd_data.
    bit [31:0] ref_mem [int unsigned];
    bit [31:0] ref_rd;

    int checks = 0;
    int errors = 0;

    function automatic int unsigned ref_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return (off / 4) % (1 << 17);
    endfunction

    function automatic bit [31:0] ref_read(input int unsigned i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One memory instruction, checked on every cycle from request to DONE.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        int unsigned i;
        logic [17:0] exp_addr;
        i = ref_idx(a);
        @(negedge clk);
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.address  = a;
        bus.wr_data  = d;
        if (w) ref_mem[i] = d;
        else if (r) ref_rd = ref_read(i);
        for (int cyc = 0; cyc <= 2 * W + 1; cyc++) begin
            #1;
            chk("ready", 32'(bus.ready), (cyc <= 2 * W) ? 32'd0 : 32'd1);
            if (cyc >= 1 && cyc <= 2 * W) begin
                exp_addr = 18'(i * 2 + ((cyc > W) ? 1 : 0));
                chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
                chk("we_n", 32'(sram_we_n), w ? 32'd0 : 32'd1);
                chk("dq_oe", 32'(sram_dq_oe), w ? 32'd1 : 32'd0);
                if (w) chk("dq_out", 32'(sram_dq_out), (cyc > W) ? 32'(d[31:16]) : 32'(d[15:0]));
            end else begin
                chk("we_n_idle", 32'(sram_we_n), 32'd1);
                chk("dq_oe_idle", 32'(sram_dq_oe), 32'd0);
            end
            if (cyc < 2 * W + 1) @(negedge clk);
        end
        chk("rd_data", bus.rd_data, ref_rd);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        #1;
        chk("ready_idle", 32'(bus.ready), 32'd1);
        chk("rd_hold", bus.rd_data, ref_rd);
    endtask

    initial begin
        int unsigned ir;
        logic [31:0] a;
        logic [31:0] d;
        int op;

        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.address  = '0;
        bus.wr_data  = '0;
        ref_rd       = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rd", bus.rd_data, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        rst = 1'b0;
        idle();

        // Store then load at 1032 (SRAM halfwords 4/5).
        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        idle();
        chk("sram4", 32'(sram[4]), 32'h0000BEEF);
        chk("sram5", 32'(sram[5]), 32'h0000DEAD);
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        idle();
        chk("load_1032", bus.rd_data, 32'hDEADBEEF);

        // Both enables: the store wins, rd_data is untouched.
        access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        idle();
        chk("both_sram0", 32'(sram[0]), 32'h00005678);
        chk("both_sram1", 32'(sram[1]), 32'h00001234);

        // Reset during WR_HI of a store to 1100 (word 19).
        @(negedge clk);
        bus.mem_w_en = 1'b1;
        bus.address  = 32'd1100;
        bus.wr_data  = 32'hCAFEF00D;
        repeat (W + 1) @(negedge clk);
        #2;
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_addr", 32'(sram_addr), 32'd39);
        bus.mem_w_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        chk("mid_rst_rd", bus.rd_data, 32'd0);
        ref_rd = '0;
        ref_mem[ref_idx(32'd1100)] = {ref_read(ref_idx(32'd1100)) >> 16, 16'hF00D} ;
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        access(1'b1, 1'b0, 32'd1100, 32'h0);
        idle();

        // Back-to-back loads: the second starts in the IDLE cycle after DONE.
        access(1'b0, 1'b1, 32'd1028, 32'hA5A55A5A);
        idle();
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        access(1'b1, 1'b0, 32'd1028, 32'h0);
        idle();

        // Randomized traffic, including wrapping out-of-range addresses.
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
            d = $urandom;
            ir = ref_idx(a);
            case (op)
                1:       access(1'b0, 1'b1, a, d);
                2:       access(1'b1, 1'b1, a, d);
                default: access(1'b1, 1'b0, a, d);
            endcase
            if (op == 0 || op == 3) chk("rand_load", bus.rd_data, ref_read(ir));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
